// File: rtl/rib_arbiter_pkg.sv
// Shared definitions for the RIB bus arbiter: master indices, FSM states,
// and the id-to-one-hot helper used by the encoder and the grant lock.
package rib_arbiter_pkg;

  localparam logic [1:0] RIB_M_CORE = 2'd0;
  localparam logic [1:0] RIB_M_PC   = 2'd1;
  localparam logic [1:0] RIB_M_JTAG = 2'd2;
  localparam logic [1:0] RIB_M_UART = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } rib_state_e;

  function automatic logic [3:0] rib_id_to_onehot(input logic [1:0] id);
    logic [3:0] oh;
    oh     = 4'b0000;
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rib_prio_enc.sv
// Four-input fixed-priority encoder: uart > core > jtag > pc.
// Also reusable by the bus for slave-side arbitration.
module rib_prio_enc
  import rib_arbiter_pkg::*;
(
  input  logic [3:0] req,
  output logic [3:0] onehot,
  output logic [1:0] id,
  output logic       valid
);

  // Pick the highest-priority requester.
  always_comb begin
    id    = RIB_M_CORE;
    valid = 1'b0;
    if (req[RIB_M_UART]) begin
      id    = RIB_M_UART;
      valid = 1'b1;
    end else if (req[RIB_M_CORE]) begin
      id    = RIB_M_CORE;
      valid = 1'b1;
    end else if (req[RIB_M_JTAG]) begin
      id    = RIB_M_JTAG;
      valid = 1'b1;
    end else if (req[RIB_M_PC]) begin
      id    = RIB_M_PC;
      valid = 1'b1;
    end else begin
      id    = RIB_M_CORE;
      valid = 1'b0;
    end
    onehot = valid ? rib_id_to_onehot(id) : 4'b0000;
  end

endmodule

// File: rtl/rib_arbiter.sv
// RIB bus arbiter: fixed-priority grant in IDLE, locked grant in WAIT for
// multi-cycle slaves, core hold flag, and timeout abort with a saturating count.
module rib_arbiter
  import rib_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req_i,
  input  logic       multi_i,
  input  logic       slave_ready_i,
  output logic [3:0] grant_o,
  output logic [1:0] grant_id_o,
  output logic       hold_flag_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       timeout_o,
  output logic [7:0] timeout_cnt_o
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  rib_state_e      state_r, state_nxt_s;
  logic [1:0]      lock_id_r, lock_id_nxt_s;
  logic [TO_W-1:0] wait_cnt_r, wait_cnt_nxt_s;
  logic [7:0]      to_cnt_r, to_cnt_nxt_s;
  logic [3:0]      win_onehot_s;
  logic [1:0]      win_id_s;
  logic            win_valid_s;
  logic            done_s, timeout_s;

  rib_prio_enc u_prio_enc (
    .req    (req_i),
    .onehot (win_onehot_s),
    .id     (win_id_s),
    .valid  (win_valid_s)
  );

  // State, lock and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      lock_id_r  <= 2'd0;
      wait_cnt_r <= '0;
      to_cnt_r   <= 8'd0;
    end else begin
      state_r    <= state_nxt_s;
      lock_id_r  <= lock_id_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      to_cnt_r   <= to_cnt_nxt_s;
    end
  end

  // Next-state logic; in WAIT, slave ready beats a dropped request, which beats timeout.
  always_comb begin
    state_nxt_s    = state_r;
    lock_id_nxt_s  = lock_id_r;
    wait_cnt_nxt_s = wait_cnt_r;
    to_cnt_nxt_s   = to_cnt_r;
    done_s         = 1'b0;
    timeout_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (win_valid_s && multi_i) begin
          lock_id_nxt_s  = win_id_s;
          wait_cnt_nxt_s = '0;
          state_nxt_s    = ST_WAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (slave_ready_i) begin
          done_s      = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (!req_i[lock_id_r]) begin
          state_nxt_s = ST_IDLE;
        end else if (wait_cnt_r == TO_LAST) begin
          timeout_s   = 1'b1;
          state_nxt_s = ST_IDLE;
          if (to_cnt_r != 8'hFF) begin
            to_cnt_nxt_s = to_cnt_r + 8'd1;
          end else begin
            to_cnt_nxt_s = to_cnt_r;
          end
        end else begin
          wait_cnt_nxt_s = wait_cnt_r + TO_W'(1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output decode; reset forces everything low without waiting for a clock.
  always_comb begin
    grant_o     = 4'b0000;
    grant_id_o  = 2'd0;
    hold_flag_o = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    timeout_o   = 1'b0;
    if (!rst) begin
      grant_o = 4'b0000;
    end else if (state_r == ST_WAIT) begin
      grant_o     = rib_id_to_onehot(lock_id_r);
      grant_id_o  = lock_id_r;
      hold_flag_o = 1'b1;
      busy_o      = 1'b1;
      done_o      = done_s;
      timeout_o   = timeout_s;
    end else begin
      grant_o     = win_onehot_s;
      grant_id_o  = win_id_s;
      hold_flag_o = win_valid_s &&
                    ((win_id_s == RIB_M_UART) || (win_id_s == RIB_M_JTAG) ||
                     ((win_id_s == RIB_M_CORE) && multi_i));
    end
  end

  assign timeout_cnt_o = to_cnt_r;

endmodule

// File: tb/tb_rib_arbiter.sv
// Self-checking bench for rib_arbiter: per-cycle comparison against a
// transaction-level model plus directed literal checks.
module tb_rib_arbiter;

  localparam int T = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       multi;
  logic       ready;
  logic [3:0] grant_o;
  logic [1:0] grant_id_o;
  logic       hold_flag_o, busy_o, done_o, timeout_o;
  logic [7:0] timeout_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  rib_arbiter #(.TIMEOUT_CYCLES(T), .TO_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_i         (req),
    .multi_i       (multi),
    .slave_ready_i (ready),
    .grant_o       (grant_o),
    .grant_id_o    (grant_id_o),
    .hold_flag_o   (hold_flag_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .timeout_o     (timeout_o),
    .timeout_cnt_o (timeout_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Highest-priority requester by the order m3, m0, m2, m1; -1 if none.
  function automatic int winner(input logic [3:0] r);
    int order [4] = '{3, 0, 2, 1};
    for (int k = 0; k < 4; k++) begin
      if (r[order[k]]) return order[k];
    end
    return -1;
  endfunction

  // Model: is a master holding the bus, which one, how long, how many timeouts.
  bit m_locked = 1'b0;
  int m_id     = 0;
  int m_age    = 0;
  int m_tocnt  = 0;

  always @(posedge clk) begin
    int w;
    w = winner(req);
    if (!rst) begin
      m_locked <= 1'b0;
      m_age    <= 0;
      m_tocnt  <= 0;
    end else if (!m_locked) begin
      if (w >= 0 && multi) begin
        m_locked <= 1'b1;
        m_id     <= w;
        m_age    <= 0;
      end
    end else if (ready || !req[m_id]) begin
      m_locked <= 1'b0;
    end else if (m_age == T - 1) begin
      m_locked <= 1'b0;
      m_tocnt  <= (m_tocnt < 255) ? m_tocnt + 1 : 255;
    end else begin
      m_age <= m_age + 1;
    end
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    logic [3:0] e_g;
    int e_id;
    logic e_hold, e_busy, e_done, e_to;
    int w;
    e_g = 4'b0000; e_id = 0; e_hold = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_to = 1'b0;
    w = winner(req);
    if (rst && m_locked) begin
      e_g       = 4'b0000;
      e_g[m_id] = 1'b1;
      e_id      = m_id;
      e_hold    = 1'b1;
      e_busy    = 1'b1;
      e_done    = ready;
      e_to      = !ready && req[m_id] && (m_age == T - 1);
    end else if (rst && w >= 0) begin
      e_g[w] = 1'b1;
      e_id   = w;
      e_hold = (w == 3) || (w == 2) || (w == 0 && multi);
    end
    check("cyc_grant", 32'(grant_o), 32'(e_g));
    check("cyc_grant_id", 32'(grant_id_o), 32'(e_id));
    check("cyc_hold", 32'(hold_flag_o), 32'(e_hold));
    check("cyc_busy", 32'(busy_o), 32'(e_busy));
    check("cyc_done", 32'(done_o), 32'(e_done));
    check("cyc_timeout", 32'(timeout_o), 32'(e_to));
    check("cyc_to_cnt", 32'(timeout_cnt_o), rst ? 32'(m_tocnt) : 32'd0);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] vec_req [5] = '{4'b0110, 4'b0101, 4'b0010, 4'b0000, 4'b1010};
  logic [3:0] vec_gnt [5] = '{4'b0100, 4'b0001, 4'b0010, 4'b0000, 4'b1000};
  logic       vec_hld [5] = '{1'b1,    1'b0,    1'b0,    1'b0,    1'b1};

  initial begin
    int nbusy;
    rst = 1'b0; req = 4'b0000; multi = 1'b0; ready = 1'b0;
    repeat (2) cyc();
    check("rst_grant", 32'(grant_o), 32'd0);
    check("rst_to_cnt", 32'(timeout_cnt_o), 32'd0);
    rst = 1'b1;

    // All masters, single-cycle: m3 wins and holds.
    req = 4'b1111; #1;
    check("all_grant", 32'(grant_o), 32'h8);
    check("all_id", 32'(grant_id_o), 32'd3);
    check("all_hold", 32'(hold_flag_o), 32'd1);
    cyc();
    check("all_idle", 32'(busy_o), 32'd0);
    req = 4'b0011; #1;
    check("m0m1_grant", 32'(grant_o), 32'h1);
    check("m0m1_hold", 32'(hold_flag_o), 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      req = vec_req[i]; #1;
      check("vec_grant", 32'(grant_o), 32'(vec_gnt[i]));
      check("vec_hold", 32'(hold_flag_o), 32'(vec_hld[i]));
    end

    // m0 multi-cycle, ready on WAIT cycle 5, m3 arrives mid-lock.
    cyc();
    req = 4'b0001; multi = 1'b1; #1;
    check("m0_multi_hold", 32'(hold_flag_o), 32'd1);
    nbusy = 0;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      multi = 1'b0;
      if (i == 3) req = 4'b1001;
      if (i == 5) ready = 1'b1;
      #1;
      if (busy_o) nbusy++;
      if (i >= 3) check("lock_grant", 32'(grant_o), 32'h1);
      if (i == 5) check("lock_done", 32'(done_o), 32'd1);
    end
    cyc();
    ready = 1'b0; #1;
    check("busy_cycles", 32'(nbusy), 32'd5);
    check("post_m3_grant", 32'(grant_o), 32'h8);
    check("post_busy", 32'(busy_o), 32'd0);

    // m2 locked, slave never ready: timeout on WAIT cycle 8.
    cyc();
    req = 4'b0100; multi = 1'b1; #1;
    for (int i = 1; i <= T; i++) begin
      cyc();
      multi = 1'b0; #1;
      if (i == T - 1) check("to_early", 32'(timeout_o), 32'd0);
      if (i == T) check("to_pulse", 32'(timeout_o), 32'd1);
    end
    cyc();
    req = 4'b0000; #1;
    check("to_release", 32'(busy_o), 32'd0);
    check("to_cnt_1", 32'(timeout_cnt_o), 32'd1);

    // Ready coincides with the timeout cycle: ready wins.
    cyc();
    req = 4'b0100; multi = 1'b1; #1;
    for (int i = 1; i <= T; i++) begin
      cyc();
      multi = 1'b0;
      if (i == T) ready = 1'b1;
      #1;
    end
    check("race_done", 32'(done_o), 32'd1);
    check("race_timeout", 32'(timeout_o), 32'd0);
    cyc();
    ready = 1'b0; req = 4'b0000; #1;
    check("race_to_cnt", 32'(timeout_cnt_o), 32'd1);

    // m0 locked, drops request on WAIT cycle 3.
    cyc();
    req = 4'b0001; multi = 1'b1; #1;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      multi = 1'b0;
      if (i == 3) req = 4'b0000;
      #1;
    end
    check("drop_done", 32'(done_o), 32'd0);
    check("drop_timeout", 32'(timeout_o), 32'd0);
    cyc();
    check("drop_idle", 32'(busy_o), 32'd0);

    // Reset mid-WAIT drops grant immediately.
    req = 4'b0001; multi = 1'b1;
    cyc();
    multi = 1'b0;
    cyc();
    check("rstw_busy", 32'(busy_o), 32'd1);
    rst = 1'b0; #1;
    check("rstw_grant", 32'(grant_o), 32'd0);
    check("rstw_hold", 32'(hold_flag_o), 32'd0);
    repeat (2) cyc();
    rst = 1'b1; #1;
    check("rstw_rearb", 32'(grant_o), 32'h1);
    check("rstw_to_cnt", 32'(timeout_cnt_o), 32'd0);

    // Forced back-to-back timeouts saturate the count.
    cyc();
    req = 4'b1000; multi = 1'b1;
    repeat (2750) cyc();
    req = 4'b0000; multi = 1'b0; #1;
    check("to_cnt_sat", 32'(timeout_cnt_o), 32'd255);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
